// File: rtl/spio_hss_multiplexer_pkt_rx_seq_if.sv
// ---------------------------------------------------------------------------
// spio_hss_multiplexer_pkt_rx_seq_if
// Bundles the frame input, packet output and ack/nak request signals of the
// receive-side sequence checker.
//   master : frame disassembler / packet consumer / frame assembler side
//            (drives frm_*, pkt_rdy, ack_gnt)
//   slave  : the sequence checker itself
//            (drives pkt_*, cfc_loc, ack_vld, nak_vld, ack_seq, empty, full)
// ---------------------------------------------------------------------------
interface spio_hss_multiplexer_pkt_rx_seq_if #(
    parameter int SEQ_BITS = 7,
    parameter int PKT_BITS = 72
);
    logic [PKT_BITS-1:0] frm_data;
    logic [SEQ_BITS-1:0] frm_seq;
    logic                frm_vld;
    logic [PKT_BITS-1:0] pkt_data;
    logic                pkt_vld;
    logic                pkt_rdy;
    logic                cfc_loc;
    logic                ack_vld;
    logic                nak_vld;
    logic [SEQ_BITS-1:0] ack_seq;
    logic                ack_gnt;
    logic                empty;
    logic                full;

    modport master (
        output frm_data, frm_seq, frm_vld, pkt_rdy, ack_gnt,
        input  pkt_data, pkt_vld, cfc_loc, ack_vld, nak_vld, ack_seq, empty, full
    );

    modport slave (
        input  frm_data, frm_seq, frm_vld, pkt_rdy, ack_gnt,
        output pkt_data, pkt_vld, cfc_loc, ack_vld, nak_vld, ack_seq, empty, full
    );
endinterface

// File: rtl/spio_hss_multiplexer_pkt_rx_seq.sv
// ---------------------------------------------------------------------------
// spio_hss_multiplexer_pkt_rx_seq
// Receive-side sequence checker for the spiNNlink frame protocol. Accepts
// decoded frames, stores in-sequence packets in a local FIFO, and raises
// ack/nak requests plus local channel flow control (cfc_loc) for the remote
// transmitter.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   bus (slave)   frm_data/frm_seq/frm_vld   incoming frame strobe
//                 pkt_data/pkt_vld/pkt_rdy   FIFO head handshake
//                 cfc_loc                    1 = remote may send
//                 ack_vld/nak_vld/ack_seq    ack/nak request, next expected seq
//                 ack_gnt                    request consumed by assembler
//                 empty/full                 FIFO status
//   oos_cnt, drop_cnt  (only with SPIO_HSS_RX_SEQ_STATS_EN) saturating counts
//                 of wrong-sequence frames and in-sequence frames lost to full
// Optional feature macro: SPIO_HSS_RX_SEQ_STATS_EN
// ---------------------------------------------------------------------------
module spio_hss_multiplexer_pkt_rx_seq #(
    parameter int SEQ_BITS   = 7,
    parameter int PKT_BITS   = 72,
    parameter int BUF_BITS   = 4,
    parameter int CFC_MARGIN = 4,
    parameter int NAK_TMO    = 64
) (
    input  logic clk,
    input  logic rst,
    spio_hss_multiplexer_pkt_rx_seq_if.slave bus
`ifdef SPIO_HSS_RX_SEQ_STATS_EN
    ,
    output logic [15:0] oos_cnt,
    output logic [15:0] drop_cnt
`endif
);
    localparam int DEPTH = 1 << BUF_BITS;
    localparam int TMO_W = $clog2(NAK_TMO);
    localparam logic [BUF_BITS:0] DEPTH_C  = (BUF_BITS+1)'(DEPTH);
    localparam logic [BUF_BITS:0] MARGIN_C = (BUF_BITS+1)'(CFC_MARGIN);
    localparam logic [BUF_BITS:0] PTR_ONE  = (BUF_BITS+1)'(1);
    localparam logic [SEQ_BITS-1:0] SEQ_ONE = SEQ_BITS'(1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(NAK_TMO - 1);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_NAKD = 1'b1;

    logic [PKT_BITS-1:0] mem_r [DEPTH];
    logic [BUF_BITS:0]   wr_ptr_r, rd_ptr_r;
    logic [SEQ_BITS-1:0] exp_seq_r, ack_seq_r;
    logic [0:0]          state_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic                ack_pend_r, nak_pend_r, ack_vld_r;
    logic                full_r, empty_r, cfc_loc_r;

    logic                accept_s, reject_s, pop_s, tmo_fire_s;
    logic [BUF_BITS:0]   wr_ptr_nxt_s, rd_ptr_nxt_s, occ_nxt_s, free_nxt_s;
    logic [SEQ_BITS-1:0] exp_seq_nxt_s, ack_seq_nxt_s;
    logic [0:0]          state_nxt_s;
    logic [TMO_W-1:0]    tmo_cnt_nxt_s;
    logic                ack_pend_nxt_s, nak_pend_nxt_s;

    // Frame classification, FIFO pointer arithmetic and ack/nak next-state.
    always_comb begin
        // full is the registered value: an in-sequence frame arriving while
        // full is rejected even if a pop happens in the same cycle.
        accept_s = bus.frm_vld && (bus.frm_seq == exp_seq_r) && !full_r;
        reject_s = bus.frm_vld && !accept_s;
        pop_s    = !empty_r && bus.pkt_rdy;

        wr_ptr_nxt_s = accept_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s    ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        occ_nxt_s    = wr_ptr_nxt_s - rd_ptr_nxt_s;
        free_nxt_s   = DEPTH_C - occ_nxt_s;

        tmo_fire_s = (state_r == ST_NAKD) && !nak_pend_r && !accept_s &&
                     (tmo_cnt_r == TMO_LAST);

        // A grant retires whichever request is currently presented (nak first).
        ack_pend_nxt_s = ack_pend_r;
        nak_pend_nxt_s = nak_pend_r;
        if (bus.ack_gnt && nak_pend_r) begin
            nak_pend_nxt_s = 1'b0;
        end else if (bus.ack_gnt && ack_pend_r) begin
            ack_pend_nxt_s = 1'b0;
        end else begin
            ack_pend_nxt_s = ack_pend_r;
        end

        // New events override a same-cycle grant.
        if (accept_s) begin
            ack_pend_nxt_s = 1'b1;
        end else begin
            ack_pend_nxt_s = ack_pend_nxt_s;
        end
        if ((reject_s && (state_r == ST_RUN)) || tmo_fire_s) begin
            nak_pend_nxt_s = 1'b1;
        end else begin
            nak_pend_nxt_s = nak_pend_nxt_s;
        end

        exp_seq_nxt_s = exp_seq_r;
        ack_seq_nxt_s = ack_seq_r;
        state_nxt_s   = state_r;
        tmo_cnt_nxt_s = tmo_cnt_r;
        if (accept_s) begin
            exp_seq_nxt_s = exp_seq_r + SEQ_ONE;
            ack_seq_nxt_s = exp_seq_r + SEQ_ONE;
            state_nxt_s   = ST_RUN;
            tmo_cnt_nxt_s = '0;
        end else if (reject_s && (state_r == ST_RUN)) begin
            ack_seq_nxt_s = exp_seq_r;
            state_nxt_s   = ST_NAKD;
            tmo_cnt_nxt_s = '0;
        end else if ((state_r == ST_NAKD) && !nak_pend_r) begin
            // Timer only runs once the outstanding nak has been consumed.
            tmo_cnt_nxt_s = tmo_fire_s ? '0 : (tmo_cnt_r + TMO_ONE);
        end else begin
            tmo_cnt_nxt_s = tmo_cnt_r;
        end
    end

    // Control state, pointers and registered status/request outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            exp_seq_r  <= '0;
            ack_seq_r  <= '0;
            state_r    <= ST_RUN;
            tmo_cnt_r  <= '0;
            ack_pend_r <= 1'b0;
            nak_pend_r <= 1'b0;
            ack_vld_r  <= 1'b0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            cfc_loc_r  <= 1'b1;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            exp_seq_r  <= exp_seq_nxt_s;
            ack_seq_r  <= ack_seq_nxt_s;
            state_r    <= state_nxt_s;
            tmo_cnt_r  <= tmo_cnt_nxt_s;
            ack_pend_r <= ack_pend_nxt_s;
            nak_pend_r <= nak_pend_nxt_s;
            ack_vld_r  <= ack_pend_nxt_s && !nak_pend_nxt_s;
            full_r     <= (occ_nxt_s == DEPTH_C);
            empty_r    <= (occ_nxt_s == '0);
            cfc_loc_r  <= (free_nxt_s > MARGIN_C);
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r[BUF_BITS-1:0]] <= bus.frm_data;
        end else begin
            mem_r[wr_ptr_r[BUF_BITS-1:0]] <= mem_r[wr_ptr_r[BUF_BITS-1:0]];
        end
    end

`ifdef SPIO_HSS_RX_SEQ_STATS_EN
    logic [15:0] oos_cnt_r, drop_cnt_r;

    // Saturating rejection statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oos_cnt_r  <= 16'h0000;
            drop_cnt_r <= 16'h0000;
        end else begin
            if (bus.frm_vld && (bus.frm_seq != exp_seq_r) && (oos_cnt_r != 16'hFFFF)) begin
                oos_cnt_r <= oos_cnt_r + 16'h0001;
            end else begin
                oos_cnt_r <= oos_cnt_r;
            end
            if (bus.frm_vld && (bus.frm_seq == exp_seq_r) && full_r && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign oos_cnt  = oos_cnt_r;
    assign drop_cnt = drop_cnt_r;
`endif

    assign bus.pkt_data = mem_r[rd_ptr_r[BUF_BITS-1:0]];
    assign bus.pkt_vld  = !empty_r;
    assign bus.cfc_loc  = cfc_loc_r;
    assign bus.ack_vld  = ack_vld_r;
    assign bus.nak_vld  = nak_pend_r;
    assign bus.ack_seq  = ack_seq_r;
    assign bus.empty    = empty_r;
    assign bus.full     = full_r;
endmodule

// File: tb/tb_spio_hss_multiplexer_pkt_rx_seq.sv
// Scoreboard bench: a behavioural model predicts every control output one
// cycle ahead and queues accepted packets; a separate monitor pops the queue
// whenever the DUT hands a packet over.
module tb_spio_hss_multiplexer_pkt_rx_seq;
    localparam int SEQ_BITS   = 7;
    localparam int PKT_BITS   = 72;
    localparam int DEPTH      = 16;
    localparam int CFC_MARGIN = 4;
    localparam int NAK_TMO    = 64;
    localparam int SEQ_MOD    = 1 << SEQ_BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spio_hss_multiplexer_pkt_rx_seq_if #(.SEQ_BITS(SEQ_BITS), .PKT_BITS(PKT_BITS)) bus ();

`ifdef SPIO_HSS_RX_SEQ_STATS_EN
    logic [15:0] oos_cnt, drop_cnt;
`endif

    spio_hss_multiplexer_pkt_rx_seq #(
        .SEQ_BITS(SEQ_BITS), .PKT_BITS(PKT_BITS), .BUF_BITS(4),
        .CFC_MARGIN(CFC_MARGIN), .NAK_TMO(NAK_TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SPIO_HSS_RX_SEQ_STATS_EN
        ,
        .oos_cnt(oos_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (protocol-level view)
    int m_exp, m_occ, m_ack_seq, m_wait;
    bit m_ack, m_nak, m_nakd;
    // Predicted outputs after the coming edge
    bit e_pkt_vld, e_ack_vld, e_nak_vld, e_cfc, e_empty, e_full;
    int e_ack_seq;
    logic [PKT_BITS-1:0] sb_q[$];

    function automatic void check(input string name, input logic [PKT_BITS-1:0] act,
                                  input logic [PKT_BITS-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_exp = 0; m_occ = 0; m_ack_seq = 0; m_wait = 0;
        m_ack = 0; m_nak = 0; m_nakd = 0;
    endfunction

    function automatic void predict();
        e_pkt_vld = (m_occ > 0);
        e_empty   = (m_occ == 0);
        e_full    = (m_occ == DEPTH);
        e_cfc     = ((DEPTH - m_occ) > CFC_MARGIN);
        e_nak_vld = m_nak;
        e_ack_vld = m_ack && !m_nak;
        e_ack_seq = m_ack_seq;
    endfunction

    task automatic compare_outputs();
        check("pkt_vld", PKT_BITS'(bus.pkt_vld), PKT_BITS'(e_pkt_vld));
        check("empty",   PKT_BITS'(bus.empty),   PKT_BITS'(e_empty));
        check("full",    PKT_BITS'(bus.full),    PKT_BITS'(e_full));
        check("cfc_loc", PKT_BITS'(bus.cfc_loc), PKT_BITS'(e_cfc));
        check("nak_vld", PKT_BITS'(bus.nak_vld), PKT_BITS'(e_nak_vld));
        check("ack_vld", PKT_BITS'(bus.ack_vld), PKT_BITS'(e_ack_vld));
        check("ack_seq", PKT_BITS'(bus.ack_seq), PKT_BITS'(e_ack_seq));
    endtask

    // One clock of protocol behaviour, using the inputs held for this edge.
    task automatic model_step();
        bit acc, rej, pop, old_nak;
        acc = bus.frm_vld && (int'(bus.frm_seq) == m_exp) && (m_occ < DEPTH);
        rej = bus.frm_vld && !acc;
        pop = (m_occ > 0) && bus.pkt_rdy;
        old_nak = m_nak;
        if (bus.ack_gnt) begin
            if (m_nak) m_nak = 0;
            else if (m_ack) m_ack = 0;
        end
        if (acc) begin
            sb_q.push_back(bus.frm_data);
            m_exp = (m_exp + 1) % SEQ_MOD;
            m_ack = 1; m_ack_seq = m_exp; m_nakd = 0; m_wait = 0;
        end else if (rej && !m_nakd) begin
            m_nak = 1; m_ack_seq = m_exp; m_nakd = 1; m_wait = 0;
        end else if (m_nakd && !old_nak) begin
            m_wait++;
            if (m_wait == NAK_TMO) begin
                m_nak = 1; m_wait = 0;
            end
        end
        m_occ = m_occ + (acc ? 1 : 0) - (pop ? 1 : 0);
    endtask

    // Model/control checker: sampled one time unit before each rising edge.
    initial begin
        model_reset();
        predict();
        forever begin
            @(negedge clk); #4;
            if (rst) begin
                model_reset();
                predict();
                compare_outputs();
            end else begin
                compare_outputs();
                model_step();
                predict();
            end
        end
    end

    // Packet monitor: pops the scoreboard on each DUT handover.
    initial begin
        logic [PKT_BITS-1:0] want;
        forever begin
            @(negedge clk); #4;
            if (rst) begin
                sb_q.delete();
            end else if (bus.pkt_vld && bus.pkt_rdy) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL pkt_unexpected: got %0h expected none at %0t", bus.pkt_data, $time);
                end else begin
                    want = sb_q.pop_front();
                    check("pkt_data", bus.pkt_data, want);
                end
            end
        end
    end

    // Drive one cycle; when rel is set the sequence is an offset from the
    // model's current expected sequence number.
    task automatic cyc(input bit vld, input bit rel, input int seq, input bit rdy, input bit gnt);
        logic [95:0] rnd;
        int s;
        @(negedge clk);
        rnd = {$urandom, $urandom, $urandom};
        s = rel ? (m_exp + seq) % SEQ_MOD : seq % SEQ_MOD;
        bus.frm_vld  = vld;
        bus.frm_seq  = s[SEQ_BITS-1:0];
        bus.frm_data = rnd[PKT_BITS-1:0];
        bus.pkt_rdy  = rdy;
        bus.ack_gnt  = gnt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.frm_vld = 1'b0; bus.ack_gnt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic random_traffic(input int n, input int rdy_pct);
        for (int i = 0; i < n; i++) begin
            cyc(($urandom % 2) == 0, 1'b1, (($urandom % 4) == 0) ? int'($urandom % SEQ_MOD) : 0,
                int'($urandom % 100) < rdy_pct, ($urandom % 3) == 0);
        end
    endtask

    initial begin
        int e;
        rst = 1'b1;
        bus.frm_vld = 1'b0; bus.frm_seq = '0; bus.frm_data = '0;
        bus.pkt_rdy = 1'b0; bus.ack_gnt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // In-order delivery and merged ack
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, i, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Gap -> single nak, recovery after grant
        e = m_exp;
        cyc(1'b1, 1'b0, e,     1'b1, 1'b0);
        cyc(1'b1, 1'b0, e + 2, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, e + 3, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0,     1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0,     1'b1, 1'b1);
        cyc(1'b1, 1'b0, e + 1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0,     1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);

        // Nak timeout re-issue, then leave NAKD with an in-sequence frame
        cyc(1'b1, 1'b1, 5, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);
        repeat (70) cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);

        // Reset in the middle of traffic
        random_traffic(12, 20);
        do_reset();

        // Sequence wrap 127 -> 0 -> 1
        for (int i = 0; i < SEQ_MOD + 2; i++) cyc(1'b1, 1'b0, i, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);

        // Fill, cfc deassertion, in-sequence frame rejected while full
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, i, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, DEPTH, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
        repeat (24) cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);
        check("drained", PKT_BITS'(sb_q.size()), PKT_BITS'(0));

        // Randomised traffic, light and heavy back-pressure
        random_traffic(2500, 60);
        random_traffic(1200, 15);
        repeat (30) cyc(1'b0, 1'b0, 0, 1'b1, 1'b1);
        check("drained_rand", PKT_BITS'(sb_q.size()), PKT_BITS'(0));

        random_traffic(20, 10);
        do_reset();
        repeat (4) cyc(1'b0, 1'b0, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
